// File: rtl/mem_access_unit_if.sv
// Request/response and Data_Memory bus bundle for mem_access_unit.
// The slave modport is the unit itself; master is the datapath plus memory side.
interface mem_access_unit_if;
    // Handshake: a request transfers on the rising edge where req_valid && req_ready.
    // req_ready is high only while the unit is idle and out of reset.
    // resp_valid is a single-cycle pulse with no back-pressure, and it qualifies
    // resp_rdata and resp_misaligned.
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;

    logic        MemWrite;
    logic        MemRead;
    logic [63:0] MemAddr;
    logic [63:0] WriteData;
    logic [63:0] ReadData;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output ReadData,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
        input  MemWrite, MemRead, MemAddr, WriteData
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  ReadData,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
        output MemWrite, MemRead, MemAddr, WriteData
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a 64-bit Data_Memory port: alignment check, read-modify-write
// for sub-doubleword stores, and sign/zero-extended load results.
module mem_access_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WAIT     = 3'd2,
        S_WR       = 3'd3,
        S_RESP     = 3'd4,
        S_RESP_ERR = 3'd5
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

    state_t      state_q;
    logic [2:0]  off_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [63:0] wdata_q;
    logic [2:0]  wait_cnt_q;

    logic        mem_write_q;
    logic        mem_read_q;
    logic [63:0] mem_addr_q;
    logic [63:0] write_data_q;
    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;
    logic        resp_mis_q;

    logic        accept_d;
    logic        misaligned_d;
    logic [5:0]  shamt_d;
    logic [63:0] mask_d;
    logic [63:0] shifted_d;
    logic [63:0] merge_data_d;
    logic [63:0] load_data_d;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign accept_d      = bus.req_valid && bus.req_ready;

    always_comb begin
        misaligned_d = 1'b0;
        case (bus.req_size)
            2'd1:    misaligned_d = bus.req_addr[0];
            2'd2:    misaligned_d = |bus.req_addr[1:0];
            2'd3:    misaligned_d = |bus.req_addr[2:0];
            default: misaligned_d = 1'b0;
        endcase
    end

    // Lane arithmetic works directly on ReadData, which is only consumed on the
    // final WAIT edge, so no separate copy of the memory word is kept.
    always_comb begin
        shamt_d      = {off_q, 3'b000};
        mask_d       = size_mask(size_q);
        merge_data_d = (bus.ReadData & ~(mask_d << shamt_d)) | ((wdata_q & mask_d) << shamt_d);
        shifted_d    = bus.ReadData >> shamt_d;
        load_data_d  = shifted_d;
        case (size_q)
            2'd0: load_data_d = unsigned_q ? {56'd0, shifted_d[7:0]}
                                           : {{56{shifted_d[7]}}, shifted_d[7:0]};
            2'd1: load_data_d = unsigned_q ? {48'd0, shifted_d[15:0]}
                                           : {{48{shifted_d[15]}}, shifted_d[15:0]};
            2'd2: load_data_d = unsigned_q ? {32'd0, shifted_d[31:0]}
                                           : {{32{shifted_d[31]}}, shifted_d[31:0]};
            default: load_data_d = shifted_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            off_q        <= 3'd0;
            size_q       <= 2'd0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= 64'd0;
            wait_cnt_q   <= 3'd0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= 64'd0;
            write_data_q <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_mis_q   <= 1'b0;
        end else begin
            // Response outputs are pulses; they are re-armed only when entering a response state.
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_mis_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        off_q      <= bus.req_addr[2:0];
                        size_q     <= bus.req_size;
                        write_q    <= bus.req_write;
                        unsigned_q <= bus.req_unsigned;
                        wdata_q    <= bus.req_wdata;
                        if (misaligned_d) begin
                            state_q      <= S_RESP_ERR;
                            resp_valid_q <= 1'b1;
                            resp_mis_q   <= 1'b1;
                        end else if (bus.req_write && bus.req_size == 2'd3) begin
                            state_q      <= S_WR;
                            mem_write_q  <= 1'b1;
                            mem_addr_q   <= {bus.req_addr[63:3], 3'b000};
                            write_data_q <= bus.req_wdata;
                        end else begin
                            state_q    <= S_RD;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {bus.req_addr[63:3], 3'b000};
                        end
                    end
                end
                S_RD: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == 3'd0) begin
                        mem_read_q <= 1'b0;
                        if (write_q) begin
                            state_q      <= S_WR;
                            mem_write_q  <= 1'b1;
                            write_data_q <= merge_data_d;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= load_data_d;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                S_WR: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                end
                S_RESP:     state_q <= S_IDLE;
                S_RESP_ERR: state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.MemWrite        = mem_write_q;
    assign bus.MemRead         = mem_read_q;
    assign bus.MemAddr         = mem_addr_q;
    assign bus.WriteData       = write_data_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_misaligned = resp_mis_q;
    assign dbg_state_o         = state_q;

endmodule
